uart_result_tx: RTL and testbench

//  Client-side driver of the UART transmit byte interface: accepts one signed binary result, formats it as ASCII

---
 rtl/uart_cal_pkg.sv | 18 +
 rtl/uart_bin2bcd.sv | 48 ++++
 rtl/uart_result_tx.sv | 137 +++++++++++++
 tb/tb_uart_result_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cal_pkg.sv
// Shared types and ASCII constants for the result-to-UART formatter.
package uart_cal_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      PICK,
      PULSE,
      WAIT_HI,
      WAIT_LO
   } state_t;

   localparam logic [7:0] ASC_MINUS = 8'h2D;
   localparam logic [7:0] ASC_ZERO  = 8'h30;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;

endpackage

// File: rtl/uart_bin2bcd.sv
// Iterative double-dabble: loads on start, then shifts one bit per cycle for DATA_W cycles.
module uart_bin2bcd #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NDIG   = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     bin,
   output logic [4*NDIG-1:0]     bcd,
   output logic                  done_c
);

   localparam int unsigned BCD_W = 4 * NDIG;
   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] bin_sr;
   logic [CNT_W-1:0]  cnt;
   logic [BCD_W-1:0]  bcd_adj;

   // add-3 correction on every digit that would overflow past 9 after the shift
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   // high in the cycle whose edge performs the final shift; bcd is complete next cycle
   assign done_c = (cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_sr <= '0;
         bcd    <= '0;
         cnt    <= '0;
      end else if (start) begin
         bin_sr <= bin;
         bcd    <= '0;
         cnt    <= CNT_W'(DATA_W);
      end else if (cnt != '0) begin
         bcd    <= {bcd_adj[BCD_W-2:0], bin_sr[DATA_W-1]};
         bin_sr <= {bin_sr[DATA_W-2:0], 1'b0};
         cnt    <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_result_tx.sv
// Formats a signed result as ASCII decimal plus line terminator and feeds it byte-wise to the UART tx.
// Optional: define UART_RESULT_CRLF_EN for a CR LF terminator (LF only otherwise).
module uart_result_tx
   import uart_cal_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NDIG   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] res_data,
   input  logic              res_valid,
   output logic              res_ready,
   output logic [7:0]        tx_data,
   output logic              uout_valid,
   input  logic              tx_valid,
   output logic              busy
);

   localparam int unsigned IDX_W = $clog2(NDIG + 3);
   localparam int unsigned BCD_W = 4 * NDIG;

   state_t            state;
   logic              sign;
   logic              fin;
   logic [IDX_W-1:0]  idx;
   logic [BCD_W-1:0]  bcd;
   logic              conv_done_c;
   logic              accept_c;
   logic [DATA_W-1:0] mag_c;

   logic [IDX_W-1:0]  lead;
   logic [IDX_W-1:0]  ndig_out;
   logic [IDX_W-1:0]  pos;
   logic [IDX_W-1:0]  dig_sel;
   logic [IDX_W-1:0]  tail;
   logic [3:0]        digit;
   logic              found;
   logic [7:0]        byte_c;

   assign accept_c = (state == IDLE) && res_valid && res_ready;
   // two's-complement magnitude; the most negative value maps to 2**(DATA_W-1) unsigned
   assign mag_c    = res_data[DATA_W-1] ? (~res_data) + DATA_W'(1) : res_data;

   uart_bin2bcd #(
      .DATA_W (DATA_W),
      .NDIG   (NDIG)
   ) u_bin2bcd (
      .clk    (clk),
      .rst    (rst),
      .start  (accept_c),
      .bin    (mag_c),
      .bcd    (bcd),
      .done_c (conv_done_c)
   );

   // byte for the current sequence index: sign, significant digits, terminator
   always_comb begin
      lead  = '0;
      found = 1'b0;
      for (int i = int'(NDIG) - 1; i > 0; i--) begin
         if (!found && bcd[i*4 +: 4] == 4'd0) lead = lead + IDX_W'(1);
         else                                 found = 1'b1;
      end
      ndig_out = IDX_W'(NDIG) - lead;
      pos      = idx - IDX_W'(sign);
      dig_sel  = IDX_W'(NDIG - 1) - lead - pos;
      digit    = 4'd0;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (dig_sel == IDX_W'(i)) digit = bcd[i*4 +: 4];
      end
      tail = pos - ndig_out;
      if (sign && idx == '0)     byte_c = ASC_MINUS;
      else if (pos < ndig_out)   byte_c = ASC_ZERO + {4'h0, digit};
`ifdef UART_RESULT_CRLF_EN
      else if (tail == '0)       byte_c = ASC_CR;
      else                       byte_c = ASC_LF;
`else
      else                       byte_c = ASC_LF;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         res_ready  <= 1'b0;
         uout_valid <= 1'b0;
         tx_data    <= 8'h00;
         busy       <= 1'b0;
         sign       <= 1'b0;
         fin        <= 1'b0;
         idx        <= '0;
      end else begin
         uout_valid <= 1'b0;
         case (state)
            IDLE: begin
               res_ready <= 1'b1;
               if (accept_c) begin
                  sign      <= res_data[DATA_W-1];
                  idx       <= '0;
                  fin       <= 1'b0;
                  busy      <= 1'b1;
                  res_ready <= 1'b0;
                  state     <= CONV;
               end
            end
            CONV: if (conv_done_c) state <= PICK;
            PICK: begin
               if (fin) begin
                  res_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  tx_data    <= byte_c;
                  fin        <= (byte_c == ASC_LF);
                  uout_valid <= !tx_valid;
                  state      <= PULSE;
               end
            end
            // pulse already launched leaves; otherwise launch once the serializer is free
            PULSE: begin
               if (uout_valid)     state      <= WAIT_HI;
               else if (!tx_valid) uout_valid <= 1'b1;
            end
            WAIT_HI: if (tx_valid) state <= WAIT_LO;
            WAIT_LO: begin
               if (!tx_valid) begin
                  idx   <= idx + IDX_W'(1);
                  state <= PICK;
                  if (fin) busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx: random and directed results against a decimal-string reference model.
module tb_uart_result_tx;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned NDIG   = 5;

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] res_data;
   logic              res_valid;
   logic              res_ready;
   logic [7:0]        tx_data;
   logic              uout_valid;
   logic              tx_valid;
   logic              busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          t_tx     = 0;
   int          overlap_cnt = 0;
   logic        tx_hold  = 1'b0;
   logic [7:0]  got_q[$];
   logic [7:0]  exp_q[$];

   uart_result_tx #(
      .DATA_W (DATA_W),
      .NDIG   (NDIG)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .res_data   (res_data),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .tx_data    (tx_data),
      .uout_valid (uout_valid),
      .tx_valid   (tx_valid),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // serializer model: busy from 2 cycles after the launch pulse for 20 cycles; bytes captured on launch
   assign tx_valid = tx_hold || (t_tx >= 2 && t_tx <= 21);

   always @(negedge clk) begin
      if (uout_valid) begin
         got_q.push_back(tx_data);
         if (tx_valid) overlap_cnt++;
         t_tx <= 1;
      end else if (t_tx > 0 && t_tx < 22) begin
         t_tx <= t_tx + 1;
      end else begin
         t_tx <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference: plain decimal rendering of the integer plus terminator
   task automatic make_expected(input int v);
      int m;
      int d[$];
      exp_q.delete();
      if (v < 0) exp_q.push_back(8'h2D);
      m = (v < 0) ? -v : v;
      do begin
         d.push_front(m % 10);
         m = m / 10;
      end while (m != 0);
      foreach (d[i]) exp_q.push_back(8'(8'h30 + d[i]));
`ifdef UART_RESULT_CRLF_EN
      exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(8'h0A);
   endtask

   task automatic compare_bytes(input string tag);
      int n;
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!res_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 32'(res_ready), 32'd1);
   endtask

   task automatic offer(input logic [DATA_W-1:0] v);
      res_data  = v;
      res_valid = 1'b1;
      @(negedge clk);
      res_valid = 1'b0;
   endtask

   task automatic run_value(input int v, input bit chk_lat, input string tag);
      int n;
      got_q.delete();
      make_expected(v);
      wait_ready(tag);
      offer(DATA_W'(v));
      check({tag, "_busy_hi"}, 32'(busy), 32'd1);
      n = 1;
      while (!uout_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (chk_lat) check({tag, "_latency"}, 32'(n), 32'd18);
      wait_ready(tag);
      compare_bytes(tag);
      check({tag, "_busy_lo"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] r;
      int n;
      rst       = 1'b1;
      res_valid = 1'b0;
      res_data  = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(res_ready), 32'd0);
      check("rst_uout", 32'(uout_valid), 32'd0);
      check("rst_txdata", 32'(tx_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rel_ready", 32'(res_ready), 32'd1);

      run_value(0, 1'b1, "zero");
      run_value(1234, 1'b1, "v1234");
      run_value(-32768, 1'b1, "vmin");
      run_value(-7, 1'b1, "vneg7");
      run_value(32767, 1'b1, "vmax");
      run_value(10000, 1'b1, "v10000");
      for (int k = 0; k < 6; k++) begin
         r = DATA_W'($urandom);
         run_value(int'($signed(r)), 1'b1, $sformatf("rnd%0d", k));
      end

      // second result offered mid-send must be ignored
      got_q.delete();
      make_expected(77);
      wait_ready("ign");
      offer(DATA_W'(77));
      n = 0;
      while (got_q.size() < 1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      res_data  = DATA_W'(999);
      res_valid = 1'b1;
      check("ign_ready", 32'(res_ready), 32'd0);
      repeat (5) @(negedge clk);
      res_valid = 1'b0;
      wait_ready("ign");
      compare_bytes("ign");

      // serializer held busy: launch withheld until it frees
      tx_hold = 1'b1;
      got_q.delete();
      make_expected(42);
      wait_ready("hold");
      offer(DATA_W'(42));
      repeat (50) @(negedge clk);
      check("hold_nopulse", 32'(got_q.size()), 32'd0);
      tx_hold = 1'b0;
      wait_ready("hold");
      compare_bytes("hold");
      check("overlap", 32'(overlap_cnt), 32'd0);

      // reset while waiting on the third frame
      got_q.delete();
      wait_ready("rst3");
      offer(DATA_W'(12345));
      n = 0;
      while (got_q.size() < 3 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("rst3_reached", 32'(got_q.size()), 32'd3);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst3_uout", 32'(uout_valid), 32'd0);
      check("rst3_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst3_ready", 32'(res_ready), 32'd1);
      repeat (40) @(negedge clk);
      check("rst3_nomore", 32'(got_q.size()), 32'd3);
      run_value(5, 1'b0, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
